axi_hp_rd_arbiter: RTL and testbench

Two-requester read arbiter for the Zynq AXI HP slave port in the FPGA embedded-system emulation top. It shares the single HP read channel between the fake-flash SPI slave (m0) and a second read requester (m1, e.g. a preload/trace engine) using round-robin arbitration. It applies the DDR base offset to every read address and keeps one burst outstanding at a time. Grant is held from AR handshake until the RLAST beat.

---
 rtl/axi_hp_rd_arbiter.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_axi_hp_rd_arbiter.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_hp_rd_arbiter.sv
//==============================================================================
// Module      : axi_hp_rd_arbiter
// Description : Two-requester round-robin read arbiter for a Zynq AXI HP
//               slave port. Shares one AXI3 read channel between requester
//               m0 (fake-flash SPI slave) and requester m1 (preload/trace
//               engine). Exactly one burst is outstanding at a time; the
//               grant is held from the AR handshake until the RLAST beat.
//               Every read address is offset by base_addr_i (carry dropped).
//
// Ports       : clk_i, rst_i            - clock, synchronous active-high reset
//               base_addr_i            - DDR window offset, sampled at capture
//               mN_ar*  (N = 0, 1)     - requester AR channels
//               mN_r*   (N = 0, 1)     - requester R channels
//               s_ar* / s_r*           - HP port AR / R channels
//               grant_o, busy_o        - owner of current burst / busy flag
//               perf_clr_i, mN_beats_o - optional beat counters
//
// Options     : `define AXI_HP_RD_ARB_PERF_EN adds the per-requester
//               accepted-beat counters (m0_beats_o, m1_beats_o) and their
//               synchronous clear input perf_clr_i.
//
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_hp_rd_arbiter #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic [AXI_ADDR_WIDTH-1:0] base_addr_i,

    // Requester 0 (fake-flash SPI slave)
    input  logic [AXI_ADDR_WIDTH-1:0] m0_araddr_i,
    input  logic [3:0]                m0_arlen_i,
    input  logic [2:0]                m0_arsize_i,
    input  logic [1:0]                m0_arburst_i,
    input  logic [AXI_ID_WIDTH-1:0]   m0_arid_i,
    input  logic                      m0_arvalid_i,
    output logic                      m0_arready_o,
    output logic [AXI_DATA_WIDTH-1:0] m0_rdata_o,
    output logic [AXI_ID_WIDTH-1:0]   m0_rid_o,
    output logic [1:0]                m0_rresp_o,
    output logic                      m0_rlast_o,
    output logic                      m0_rvalid_o,
    input  logic                      m0_rready_i,

    // Requester 1 (preload / trace engine)
    input  logic [AXI_ADDR_WIDTH-1:0] m1_araddr_i,
    input  logic [3:0]                m1_arlen_i,
    input  logic [2:0]                m1_arsize_i,
    input  logic [1:0]                m1_arburst_i,
    input  logic [AXI_ID_WIDTH-1:0]   m1_arid_i,
    input  logic                      m1_arvalid_i,
    output logic                      m1_arready_o,
    output logic [AXI_DATA_WIDTH-1:0] m1_rdata_o,
    output logic [AXI_ID_WIDTH-1:0]   m1_rid_o,
    output logic [1:0]                m1_rresp_o,
    output logic                      m1_rlast_o,
    output logic                      m1_rvalid_o,
    input  logic                      m1_rready_i,

    // HP slave port
    output logic [AXI_ADDR_WIDTH-1:0] s_araddr_o,
    output logic [3:0]                s_arlen_o,
    output logic [2:0]                s_arsize_o,
    output logic [1:0]                s_arburst_o,
    output logic [AXI_ID_WIDTH-1:0]   s_arid_o,
    output logic                      s_arvalid_o,
    input  logic                      s_arready_i,
    input  logic [AXI_DATA_WIDTH-1:0] s_rdata_i,
    input  logic [AXI_ID_WIDTH-1:0]   s_rid_i,
    input  logic [1:0]                s_rresp_i,
    input  logic                      s_rlast_i,
    input  logic                      s_rvalid_i,
    output logic                      s_rready_o,

    // Status
    output logic                      grant_o,
    output logic                      busy_o
`ifdef AXI_HP_RD_ARB_PERF_EN
    ,
    input  logic                      perf_clr_i,
    output logic [31:0]               m0_beats_o,
    output logic [31:0]               m1_beats_o
`endif
);

    //--------------------------------------------------------------------------
    // State encoding
    //--------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_addr = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;

    logic                      r_grant;
    logic                      r_rr_ptr;

    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [3:0]                r_arlen;
    logic [2:0]                r_arsize;
    logic [1:0]                r_arburst;
    logic [AXI_ID_WIDTH-1:0]   r_arid;

    logic                      w_any_req;
    logic                      w_winner;
    logic                      w_capture;
    logic                      w_r_hs;
    logic                      w_r_last_hs;

    logic [AXI_ADDR_WIDTH-1:0] w_sel_araddr;
    logic [3:0]                w_sel_arlen;
    logic [2:0]                w_sel_arsize;
    logic [1:0]                w_sel_arburst;
    logic [AXI_ID_WIDTH-1:0]   w_sel_arid;

    //--------------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on a tie the round-robin
    // pointer decides. The loser keeps arvalid high and is picked up on the
    // next IDLE cycle because the pointer flips to it after each burst.
    //--------------------------------------------------------------------------
    assign w_any_req = m0_arvalid_i | m1_arvalid_i;
    assign w_winner  = (m0_arvalid_i & m1_arvalid_i) ? r_rr_ptr : m1_arvalid_i;
    assign w_capture = (r_state == c_st_idle) & w_any_req;

    assign w_sel_araddr  = w_winner ? m1_araddr_i  : m0_araddr_i;
    assign w_sel_arlen   = w_winner ? m1_arlen_i   : m0_arlen_i;
    assign w_sel_arsize  = w_winner ? m1_arsize_i  : m0_arsize_i;
    assign w_sel_arburst = w_winner ? m1_arburst_i : m0_arburst_i;
    assign w_sel_arid    = w_winner ? m1_arid_i    : m0_arid_i;

    // R handshake on the HP side; s_rready_o is already gated to DATA state.
    assign w_r_hs      = s_rvalid_i & s_rready_o;
    assign w_r_last_hs = w_r_hs & s_rlast_i;

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_any_req)   w_state_nxt = c_st_addr;
            c_st_addr: if (s_arready_i) w_state_nxt = c_st_data;
            c_st_data: if (w_r_last_hs) w_state_nxt = c_st_idle;
            default:                    w_state_nxt = c_st_idle;
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------------
    always_comb begin
        m0_arready_o = 1'b0;
        m1_arready_o = 1'b0;
        s_arvalid_o  = 1'b0;
        s_rready_o   = 1'b0;
        m0_rvalid_o  = 1'b0;
        m1_rvalid_o  = 1'b0;
        busy_o       = 1'b0;
        case (r_state)
            c_st_idle: begin
                // Ready goes only to the winner, so the handshake and the
                // payload capture below always refer to the same requester.
                m0_arready_o = m0_arvalid_i & ~w_winner;
                m1_arready_o = m1_arvalid_i &  w_winner;
            end
            c_st_addr: begin
                s_arvalid_o = 1'b1;
                busy_o      = 1'b1;
            end
            c_st_data: begin
                busy_o      = 1'b1;
                s_rready_o  = r_grant ? m1_rready_i : m0_rready_i;
                m0_rvalid_o = s_rvalid_i & ~r_grant;
                m1_rvalid_o = s_rvalid_i &  r_grant;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // AR payload capture and grant / round-robin bookkeeping
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_arid    <= '0;
            r_grant   <= 1'b0;
        end else if (w_capture) begin
            // Offset add wraps modulo 2^AXI_ADDR_WIDTH; the carry is dropped.
            r_araddr  <= w_sel_araddr + base_addr_i;
            r_arlen   <= w_sel_arlen;
            r_arsize  <= w_sel_arsize;
            r_arburst <= w_sel_arburst;
            r_arid    <= w_sel_arid;
            r_grant   <= w_winner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr <= 1'b0;
        end else if ((r_state == c_st_data) && w_r_last_hs) begin
            r_rr_ptr <= ~r_grant;
        end
    end

    //--------------------------------------------------------------------------
    // HP AR payload and status
    //--------------------------------------------------------------------------
    assign s_araddr_o  = r_araddr;
    assign s_arlen_o   = r_arlen;
    assign s_arsize_o  = r_arsize;
    assign s_arburst_o = r_arburst;
    assign s_arid_o    = r_arid;
    assign grant_o     = r_grant;

    //--------------------------------------------------------------------------
    // R payload fan-out. Data/ID/resp/last go to both requesters; only the
    // granted one sees rvalid, so the other simply ignores the payload.
    // Routing uses the registered grant, never the returned ID.
    //--------------------------------------------------------------------------
    assign m0_rdata_o = s_rdata_i;
    assign m0_rid_o   = s_rid_i;
    assign m0_rresp_o = s_rresp_i;
    assign m0_rlast_o = s_rlast_i;

    assign m1_rdata_o = s_rdata_i;
    assign m1_rid_o   = s_rid_i;
    assign m1_rresp_o = s_rresp_i;
    assign m1_rlast_o = s_rlast_i;

`ifdef AXI_HP_RD_ARB_PERF_EN
    //--------------------------------------------------------------------------
    // Accepted-beat counters, saturating. Clear has priority over a beat
    // arriving in the same cycle.
    //--------------------------------------------------------------------------
    localparam logic [31:0] c_beats_max = 32'hFFFF_FFFF;

    logic [31:0] r_m0_beats;
    logic [31:0] r_m1_beats;

    always_ff @(posedge clk_i) begin
        if (rst_i || perf_clr_i) begin
            r_m0_beats <= '0;
            r_m1_beats <= '0;
        end else begin
            if (w_r_hs && !r_grant && (r_m0_beats != c_beats_max)) begin
                r_m0_beats <= r_m0_beats + 32'd1;
            end
            if (w_r_hs && r_grant && (r_m1_beats != c_beats_max)) begin
                r_m1_beats <= r_m1_beats + 32'd1;
            end
        end
    end

    assign m0_beats_o = r_m0_beats;
    assign m1_beats_o = r_m1_beats;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_hp_rd_arbiter.sv
//==============================================================================
// Module      : tb_axi_hp_rd_arbiter
// Description : Self-checking bench for axi_hp_rd_arbiter. Expected AR
//               transactions and R beats are queued when a request is issued
//               and compared when the HP slave model / requester monitors
//               observe them.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_hp_rd_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic [AW-1:0] base_addr_i;

    logic [AW-1:0] m0_araddr_i, m1_araddr_i;
    logic [3:0]    m0_arlen_i, m1_arlen_i;
    logic [2:0]    m0_arsize_i, m1_arsize_i;
    logic [1:0]    m0_arburst_i, m1_arburst_i;
    logic [IW-1:0] m0_arid_i, m1_arid_i;
    logic          m0_arvalid_i, m1_arvalid_i;
    logic          m0_arready_o, m1_arready_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic [IW-1:0] m0_rid_o, m1_rid_o;
    logic [1:0]    m0_rresp_o, m1_rresp_o;
    logic          m0_rlast_o, m1_rlast_o;
    logic          m0_rvalid_o, m1_rvalid_o;
    logic          m0_rready_i, m1_rready_i;

    logic [AW-1:0] s_araddr_o;
    logic [3:0]    s_arlen_o;
    logic [2:0]    s_arsize_o;
    logic [1:0]    s_arburst_o;
    logic [IW-1:0] s_arid_o;
    logic          s_arvalid_o;
    logic          s_arready_i;
    logic [DW-1:0] s_rdata_i;
    logic [IW-1:0] s_rid_i;
    logic [1:0]    s_rresp_i;
    logic          s_rlast_i;
    logic          s_rvalid_i;
    logic          s_rready_o;
    logic          grant_o;
    logic          busy_o;
`ifdef AXI_HP_RD_ARB_PERF_EN
    logic          perf_clr_i;
    logic [31:0]   m0_beats_o;
    logic [31:0]   m1_beats_o;
`endif

    axi_hp_rd_arbiter #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .base_addr_i  (base_addr_i),
        .m0_araddr_i  (m0_araddr_i),
        .m0_arlen_i   (m0_arlen_i),
        .m0_arsize_i  (m0_arsize_i),
        .m0_arburst_i (m0_arburst_i),
        .m0_arid_i    (m0_arid_i),
        .m0_arvalid_i (m0_arvalid_i),
        .m0_arready_o (m0_arready_o),
        .m0_rdata_o   (m0_rdata_o),
        .m0_rid_o     (m0_rid_o),
        .m0_rresp_o   (m0_rresp_o),
        .m0_rlast_o   (m0_rlast_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_rready_i  (m0_rready_i),
        .m1_araddr_i  (m1_araddr_i),
        .m1_arlen_i   (m1_arlen_i),
        .m1_arsize_i  (m1_arsize_i),
        .m1_arburst_i (m1_arburst_i),
        .m1_arid_i    (m1_arid_i),
        .m1_arvalid_i (m1_arvalid_i),
        .m1_arready_o (m1_arready_o),
        .m1_rdata_o   (m1_rdata_o),
        .m1_rid_o     (m1_rid_o),
        .m1_rresp_o   (m1_rresp_o),
        .m1_rlast_o   (m1_rlast_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_rready_i  (m1_rready_i),
        .s_araddr_o   (s_araddr_o),
        .s_arlen_o    (s_arlen_o),
        .s_arsize_o   (s_arsize_o),
        .s_arburst_o  (s_arburst_o),
        .s_arid_o     (s_arid_o),
        .s_arvalid_o  (s_arvalid_o),
        .s_arready_i  (s_arready_i),
        .s_rdata_i    (s_rdata_i),
        .s_rid_i      (s_rid_i),
        .s_rresp_i    (s_rresp_i),
        .s_rlast_i    (s_rlast_i),
        .s_rvalid_i   (s_rvalid_i),
        .s_rready_o   (s_rready_o),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
`ifdef AXI_HP_RD_ARB_PERF_EN
        ,
        .perf_clr_i   (perf_clr_i),
        .m0_beats_o   (m0_beats_o),
        .m1_beats_o   (m1_beats_o)
`endif
    );

    //--------------------------------------------------------------------------
    // Scoreboard
    //--------------------------------------------------------------------------
    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [5:0]  id;
    } ar_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [5:0]  id;
        logic [1:0]  resp;
    } beat_t;

    ar_t   q_ar[$];
    beat_t q_r0[$];
    beat_t q_r1[$];

    int n_tests = 0;
    int n_fail  = 0;
    int ar_stall = 0;
    int hold0 = 0;
    int r0_cnt = 0;
    int r1_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int i);
        return (a + 32'(i)) ^ 32'hA5A5_0000;
    endfunction

    // Queue the AR the HP port must see and the beats the requester must get.
    task automatic expect_burst(input int m, input logic [31:0] addr,
                                input logic [3:0] len, input logic [5:0] id);
        ar_t   a;
        beat_t b;
        a.m    = m;
        a.addr = addr + base_addr_i;
        a.len  = len;
        a.id   = id;
        q_ar.push_back(a);
        for (int i = 0; i <= int'(len); i++) begin
            b.data = beat_data(a.addr, i);
            b.last = (i == int'(len));
            b.id   = id;
            b.resp = 2'(i);
            if (m == 0) q_r0.push_back(b);
            else        q_r1.push_back(b);
        end
    endtask

    // Issue one AR on requester m and check the one-cycle AR latency.
    task automatic drive_req(input int m, input logic [31:0] addr,
                             input logic [3:0] len, input logic [5:0] id);
        int          n;
        logic [31:0] exp_addr;
        n        = 0;
        exp_addr = addr + base_addr_i;
        @(posedge clk); #1;
        if (m == 0) begin
            m0_araddr_i = addr; m0_arlen_i = len; m0_arid_i = id; m0_arvalid_i = 1'b1;
        end else begin
            m1_araddr_i = addr; m1_arlen_i = len; m1_arid_i = id; m1_arvalid_i = 1'b1;
        end
        @(negedge clk);
        while (!((m == 0) ? m0_arready_o : m1_arready_o) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            check((m == 0) ? "m0_ar_timeout" : "m1_ar_timeout", 0, 1);
            if (m == 0) m0_arvalid_i = 1'b0; else m1_arvalid_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (m == 0) m0_arvalid_i = 1'b0; else m1_arvalid_i = 1'b0;
        @(negedge clk);
        check("ar_latency_valid", s_arvalid_o, 1);
        check("ar_latency_addr", s_araddr_o, exp_addr);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q_ar.size() != 0 || q_r0.size() != 0 || q_r1.size() != 0 || busy_o) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("burst_complete_timeout", (n < 500), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        q_ar.delete();
        q_r0.delete();
        q_r1.delete();
    endtask

    //--------------------------------------------------------------------------
    // HP slave model: optional AR stall, then returns len+1 beats whose data
    // is derived from the address it received.
    //--------------------------------------------------------------------------
    ar_t         sl_exp;
    logic [31:0] sl_first;
    logic [31:0] sl_addr;
    logic [3:0]  sl_len;
    logic [5:0]  sl_id;
    int          sl_wait;

    initial begin
        s_arready_i = 1'b1;
        s_rvalid_i  = 1'b0;
        s_rdata_i   = '0;
        s_rid_i     = '0;
        s_rresp_i   = '0;
        s_rlast_i   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_i && s_arvalid_o) begin
                sl_first = s_araddr_o;
                for (int k = 0; k < ar_stall; k++) begin
                    @(negedge clk);
                    check("ar_stall_valid", s_arvalid_o, 1);
                    check("ar_stall_addr", s_araddr_o, sl_first);
                end
                s_arready_i = 1'b1;
                sl_addr = s_araddr_o;
                sl_len  = s_arlen_o;
                sl_id   = s_arid_o;
                if (q_ar.size() == 0) begin
                    check("ar_unexpected", 1, 0);
                end else begin
                    sl_exp = q_ar.pop_front();
                    check("ar_addr", s_araddr_o, sl_exp.addr);
                    check("ar_len", s_arlen_o, sl_exp.len);
                    check("ar_id", s_arid_o, sl_exp.id);
                    check("ar_size", s_arsize_o, 3'b010);
                    check("ar_burst", s_arburst_o, 2'b01);
                    check("ar_grant", grant_o, sl_exp.m[0]);
                end
                @(posedge clk); #1;
                s_arready_i = (ar_stall == 0);
                for (int i = 0; i <= int'(sl_len); i++) begin
                    s_rvalid_i = 1'b1;
                    s_rdata_i  = beat_data(sl_addr, i);
                    s_rid_i    = sl_id;
                    s_rresp_i  = 2'(i);
                    s_rlast_i  = (i == int'(sl_len));
                    sl_wait    = 0;
                    @(negedge clk);
                    while (!rst_i && !s_rready_o && sl_wait < 100) begin
                        @(negedge clk);
                        sl_wait++;
                    end
                    if (rst_i) break;
                    if (sl_wait >= 100) begin
                        check("r_ready_timeout", 0, 1);
                        break;
                    end
                    @(posedge clk); #1;
                end
                s_rvalid_i = 1'b0;
                s_rlast_i  = 1'b0;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Requester-side R monitors and m0 back-pressure
    //--------------------------------------------------------------------------
    beat_t mon_b;

    initial begin
        m0_rready_i = 1'b1;
        m1_rready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            m0_rready_i = (hold0 == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (m0_rvalid_o && m0_rready_i) begin
                    if (q_r0.size() == 0) begin
                        check("m0_unexpected_beat", 1, 0);
                    end else begin
                        mon_b = q_r0.pop_front();
                        check("m0_rdata", m0_rdata_o, mon_b.data);
                        check("m0_rlast", m0_rlast_o, mon_b.last);
                        check("m0_rid", m0_rid_o, mon_b.id);
                        check("m0_rresp", m0_rresp_o, mon_b.resp);
                    end
                    check("m0_beat_grant", grant_o, 0);
                    check("m1_rvalid_quiet", m1_rvalid_o, 0);
                    r0_cnt++;
                end
                if (m1_rvalid_o && m1_rready_i) begin
                    if (q_r1.size() == 0) begin
                        check("m1_unexpected_beat", 1, 0);
                    end else begin
                        mon_b = q_r1.pop_front();
                        check("m1_rdata", m1_rdata_o, mon_b.data);
                        check("m1_rlast", m1_rlast_o, mon_b.last);
                        check("m1_rid", m1_rid_o, mon_b.id);
                        check("m1_rresp", m1_rresp_o, mon_b.resp);
                    end
                    check("m1_beat_grant", grant_o, 1);
                    check("m0_rvalid_quiet", m0_rvalid_o, 0);
                    r1_cnt++;
                end
                if (m0_rvalid_o && !m0_rready_i && hold0 > 0) hold0--;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    //--------------------------------------------------------------------------
    // Main sequence
    //--------------------------------------------------------------------------
    initial begin
        int n;
        rst_i        = 1'b1;
        base_addr_i  = '0;
        m0_araddr_i  = '0; m0_arlen_i = '0; m0_arsize_i = 3'b010; m0_arburst_i = 2'b01;
        m0_arid_i    = '0; m0_arvalid_i = 1'b0;
        m1_araddr_i  = '0; m1_arlen_i = '0; m1_arsize_i = 3'b010; m1_arburst_i = 2'b01;
        m1_arid_i    = '0; m1_arvalid_i = 1'b0;
`ifdef AXI_HP_RD_ARB_PERF_EN
        perf_clr_i   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_arvalid", s_arvalid_o, 0);
        check("rst_s_rready", s_rready_o, 0);
        check("rst_m0_rvalid", m0_rvalid_o, 0);
        check("rst_m1_rvalid", m1_rvalid_o, 0);
        check("rst_s_araddr", s_araddr_o, 0);
        check("rst_s_arid", s_arid_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_busy", busy_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        // m0 alone with base offset
        base_addr_i = 32'h1000_0000;
        expect_burst(0, 32'h0000_1000, 4'd3, 6'h05);
        drive_req(0, 32'h0000_1000, 4'd3, 6'h05);
        wait_done();

        // Simultaneous requests after reset: m0, m1, then m0, m1 again
        do_reset();
        base_addr_i = 32'h2000_0000;
        expect_burst(0, 32'h0000_2000, 4'd1, 6'h01);
        expect_burst(1, 32'h0000_3000, 4'd2, 6'h02);
        fork
            drive_req(0, 32'h0000_2000, 4'd1, 6'h01);
            drive_req(1, 32'h0000_3000, 4'd2, 6'h02);
        join
        expect_burst(0, 32'h0000_2100, 4'd0, 6'h03);
        expect_burst(1, 32'h0000_3100, 4'd1, 6'h04);
        fork
            drive_req(0, 32'h0000_2100, 4'd0, 6'h03);
            drive_req(1, 32'h0000_3100, 4'd1, 6'h04);
        join
        wait_done();

        // Address wrap
        base_addr_i = 32'hFFFF_F000;
        expect_burst(1, 32'h0000_2000, 4'd2, 6'h11);
        drive_req(1, 32'h0000_2000, 4'd2, 6'h11);
        wait_done();

        // AR stall, R back-pressure on m0, m1 arriving mid-burst
        base_addr_i = 32'h0100_0000;
        ar_stall    = 5;
        s_arready_i = 1'b0;
        hold0       = 3;
        expect_burst(0, 32'h0000_4000, 4'd7, 6'h21);
        expect_burst(1, 32'h0000_5000, 4'd0, 6'h22);
        fork
            drive_req(0, 32'h0000_4000, 4'd7, 6'h21);
            begin
                repeat (2) @(posedge clk);
                drive_req(1, 32'h0000_5000, 4'd0, 6'h22);
            end
        join
        wait_done();
        check("rready_stall_consumed", hold0, 0);
        ar_stall    = 0;
        s_arready_i = 1'b1;

        // Reset in the middle of an 8-beat burst
        base_addr_i = 32'h0;
        r0_cnt      = 0;
        expect_burst(0, 32'h0000_6000, 4'd7, 6'h31);
        drive_req(0, 32'h0000_6000, 4'd7, 6'h31);
        n = 0;
        while (r0_cnt < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midburst_reach_beat2", (r0_cnt >= 2), 1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy_o, 0);
        check("midrst_s_arvalid", s_arvalid_o, 0);
        check("midrst_m0_rvalid", m0_rvalid_o, 0);
        check("midrst_m1_rvalid", m1_rvalid_o, 0);
        check("midrst_s_rready", s_rready_o, 0);
        check("midrst_grant", grant_o, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        q_ar.delete();
        q_r0.delete();
        q_r1.delete();
        expect_burst(1, 32'h0000_7000, 4'd1, 6'h32);
        drive_req(1, 32'h0000_7000, 4'd1, 6'h32);
        wait_done();

`ifdef AXI_HP_RD_ARB_PERF_EN
        do_reset();
        @(negedge clk);
        check("perf_rst_m0", m0_beats_o, 0);
        check("perf_rst_m1", m1_beats_o, 0);
        base_addr_i = 32'h0;
        expect_burst(0, 32'h0000_8000, 4'd3, 6'h01);
        drive_req(0, 32'h0000_8000, 4'd3, 6'h01);
        wait_done();
        expect_burst(0, 32'h0000_8100, 4'd3, 6'h02);
        drive_req(0, 32'h0000_8100, 4'd3, 6'h02);
        wait_done();
        expect_burst(1, 32'h0000_9000, 4'd0, 6'h03);
        drive_req(1, 32'h0000_9000, 4'd0, 6'h03);
        wait_done();
        check("perf_m0_beats", m0_beats_o, 8);
        check("perf_m1_beats", m1_beats_o, 1);
        @(posedge clk); #1;
        perf_clr_i = 1'b1;
        @(posedge clk); #1;
        perf_clr_i = 1'b0;
        @(negedge clk);
        check("perf_clr_m0", m0_beats_o, 0);
        check("perf_clr_m1", m1_beats_o, 0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
